uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 124 ++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: the host pushes bytes, and a small launcher
// pops one byte at a time and hands it over with a one-cycle tx_en strobe.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    tx_data,
    output logic          tx_en,
    input  logic          tx_busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    state_t        state;
    state_t        state_nxt;
    logic          push;
    logic          pop;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // Flush outranks both sides: a pushed byte is dropped and no new pop starts.
    assign push = wr_en && !full && !flush;
    assign pop  = (state == IDLE) && !empty && !tx_busy && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // tx_data is only reloaded by a pop, so it stays put through the whole launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data <= 8'h00;
        end else if (pop) begin
            tx_data <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_en     = 1'b0;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_en     = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
